// File: rtl/instruction_register.sv
// Instruction register: holds the fetched 16-bit word and slices it into overlapping decode fields.
// Optional macro IR_LOADED_FLAG_EN adds a sticky `loaded` flag set by the first write after reset.
module instruction_register (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        w,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic [5:0]  OPCODE,
  output logic        REGISTER_ADRESS,
  output logic [1:0]  REGISTER_ADRESS_STACK,
  output logic [8:0]  IMMEDIATE,
  output logic [9:0]  BA
`ifdef IR_LOADED_FLAG_EN
  ,
  output logic        loaded
`endif
);

  logic [15:0] ir_q, ir_d;

  always_comb begin
    ir_d = ir_q;
    if (w) begin
      ir_d = in;
    end
  end

  // Reset is synchronous and takes priority over the write strobe.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ir_q <= 16'h0000;
    end else begin
      ir_q <= ir_d;
    end
  end

`ifdef IR_LOADED_FLAG_EN
  logic loaded_q, loaded_d;

  always_comb begin
    loaded_d = loaded_q;
    if (w) begin
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
    end
  end

  assign loaded = loaded_q;
`endif

  // Fields overlap on bits 9 and 8; the instruction format decides which one is meaningful.
  always_comb begin
    out                   = ir_q;
    OPCODE                = ir_q[15:10];
    REGISTER_ADRESS       = ir_q[9];
    REGISTER_ADRESS_STACK = ir_q[9:8];
    IMMEDIATE             = ir_q[8:0];
    BA                    = ir_q[9:0];
  end

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register.
// Checks of `loaded` are compiled in only when IR_LOADED_FLAG_EN is defined.
module tb_instruction_register;

  logic        CLK;
  logic        RESET;
  logic        w;
  logic [15:0] in;
  logic [15:0] out;
  logic [5:0]  OPCODE;
  logic        REGISTER_ADRESS;
  logic [1:0]  REGISTER_ADRESS_STACK;
  logic [8:0]  IMMEDIATE;
  logic [9:0]  BA;
`ifdef IR_LOADED_FLAG_EN
  logic        loaded;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  instruction_register dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .w                     (w),
    .in                    (in),
    .out                   (out),
    .OPCODE                (OPCODE),
    .REGISTER_ADRESS       (REGISTER_ADRESS),
    .REGISTER_ADRESS_STACK (REGISTER_ADRESS_STACK),
    .IMMEDIATE             (IMMEDIATE),
    .BA                    (BA)
`ifdef IR_LOADED_FLAG_EN
    ,
    .loaded                (loaded)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the rising edge, then sample just after it.
  task automatic step(input logic rst_v, input logic w_v, input logic [15:0] in_v);
    @(negedge CLK);
    RESET = rst_v;
    w     = w_v;
    in    = in_v;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic [15:0] exp_out,
                              input logic [5:0] exp_opc, input logic exp_ra,
                              input logic [1:0] exp_ras, input logic [8:0] exp_imm,
                              input logic [9:0] exp_ba);
    check_eq({tag, ".out"},    out,                            exp_out);
    check_eq({tag, ".opcode"}, {10'd0, OPCODE},                {10'd0, exp_opc});
    check_eq({tag, ".ra"},     {15'd0, REGISTER_ADRESS},       {15'd0, exp_ra});
    check_eq({tag, ".ras"},    {14'd0, REGISTER_ADRESS_STACK}, {14'd0, exp_ras});
    check_eq({tag, ".imm"},    {7'd0, IMMEDIATE},              {7'd0, exp_imm});
    check_eq({tag, ".ba"},     {6'd0, BA},                     {6'd0, exp_ba});
  endtask

  task automatic check_loaded(input string tag, input logic exp_loaded);
`ifdef IR_LOADED_FLAG_EN
    check_eq({tag, ".loaded"}, {15'd0, loaded}, {15'd0, exp_loaded});
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET    = 1'b1;
    w        = 1'b0;
    in       = 16'h0000;

    // Reset with a live word on `in`
    step(1'b0, 1'b0, 16'b0110101010110011);
    check_fields("reset", 16'h0000, 6'h00, 1'b0, 2'b00, 9'h000, 10'h000);
    check_loaded("reset", 1'b0);

    // Load
    step(1'b1, 1'b1, 16'b0110101010110011);
    check_fields("load", 16'b0110101010110011, 6'b011010, 1'b1, 2'b10, 9'b010110011,
                 10'b1010110011);
    check_loaded("load", 1'b1);

    // Hold: new `in` with w low is ignored
    step(1'b1, 1'b0, 16'b0001011011110100);
    check_fields("hold", 16'b0110101010110011, 6'b011010, 1'b1, 2'b10, 9'b010110011,
                 10'b1010110011);
    check_loaded("hold", 1'b1);

    // Mid-cycle change on `in` with w high must not reach outputs before an edge
    @(negedge CLK);
    w  = 1'b1;
    in = 16'hAAAA;
    #2;
    check_eq("between_edges.out", out, 16'b0110101010110011);
    w  = 1'b0;

    // Reset priority over write
    step(1'b0, 1'b1, 16'hFFFF);
    check_fields("rst_prio", 16'h0000, 6'h00, 1'b0, 2'b00, 9'h000, 10'h000);
    check_loaded("rst_prio", 1'b0);

    // Field boundaries
    step(1'b1, 1'b1, 16'hFC00);
    check_fields("fc00", 16'hFC00, 6'h3F, 1'b0, 2'b00, 9'h000, 10'h000);
    check_loaded("fc00", 1'b1);
    step(1'b1, 1'b1, 16'h03FF);
    check_fields("03ff", 16'h03FF, 6'h00, 1'b1, 2'b11, 9'h1FF, 10'h3FF);

    // Back-to-back writes, each visible right after its edge
    step(1'b1, 1'b1, 16'h1234);
    check_eq("b2b0.out", out, 16'h1234);
    step(1'b1, 1'b1, 16'h5678);
    check_eq("b2b1.out", out, 16'h5678);
    step(1'b1, 1'b1, 16'h9ABC);
    check_fields("b2b2", 16'h9ABC, 6'b100110, 1'b1, 2'b10, 9'h0BC, 10'h2BC);

    // Single-edge reset mid-program loses the held word; flag stays clear while w is low
    step(1'b0, 1'b0, 16'h9ABC);
    check_fields("mid_rst", 16'h0000, 6'h00, 1'b0, 2'b00, 9'h000, 10'h000);
    step(1'b1, 1'b0, 16'h4321);
    check_eq("post_rst_hold.out", out, 16'h0000);
    check_loaded("post_rst_hold", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_register.md
# instruction_register

16-bit instruction register for the pocket-calculator CPU datapath. It captures the instruction word fetched from program memory when the control unit asserts the write strobe. It holds that word until the next write or reset. It continuously decodes the held word into opcode, register-address, stack-address, immediate and branch-address fields for the control unit and datapath.

## Interface
- No parameters; all widths are fixed.
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on CLK rising edge.
- w  input  1  write enable; loads `in` on a rising edge while RESET is high.
- in  input  16  instruction word from program memory.
- out  output  16  currently held instruction word.
- OPCODE  output  6  out[15:10].
- REGISTER_ADRESS  output  1  out[9]: accumulator/register select.
- REGISTER_ADRESS_STACK  output  2  out[9:8]: stack register select.
- IMMEDIATE  output  9  out[8:0]: immediate operand.
- BA  output  10  out[9:0]: branch address.
- loaded  output  1  present only with IR_LOADED_FLAG_EN (see Configuration).

## Operation
- Single 16-bit storage register `ir`.
- Rising CLK edge, in priority order:
  - RESET == 0: ir <= 16'h0000. Reset overrides w.
  - RESET == 1 and w == 1: ir <= in.
  - Otherwise: ir holds its value.
- out = ir.
- All field outputs are pure combinational slices of ir:
  - The fields overlap deliberately. The instruction format determines which field is meaningful; the block does not qualify any field by opcode.
  - Bit 9 appears in REGISTER_ADRESS, REGISTER_ADRESS_STACK[1] and BA[9].
  - Bit 8 appears in REGISTER_ADRESS_STACK[0], IMMEDIATE[8] and BA[8].
- No opcode validation and no sign extension; IMMEDIATE and BA are raw bits.
- Changes on `in` while w == 0, or between edges, have no effect on any output.

## Timing
- Write latency is one edge: the value on `in` at rising edge N appears on out and all fields immediately after edge N. There is no further pipeline stage.
- Field outputs settle combinationally with out, so they are valid in the same cycle as out.
- Reset is synchronous. The block has no asynchronous path, and state is undefined until the first rising edge with RESET low.
- Reset values: out = 0, OPCODE = 0, REGISTER_ADRESS = 0, REGISTER_ADRESS_STACK = 0, IMMEDIATE = 0, BA = 0, loaded = 0.
- RESET low for one edge mid-program clears the register at that edge; the previously held instruction is lost.
- w held high for several edges reloads `in` each edge; the last sampled value wins.
- RESET low together with w high: the register clears and `in` is discarded.

## Configuration
- Macro: IR_LOADED_FLAG_EN.
- Defined:
  - Adds the 1-bit output `loaded`.
  - `loaded` clears to 0 on reset.
  - It sets to 1 on the first edge with RESET high and w high, and stays 1 until the next reset.
  - The control unit uses it to block execution of the all-zero reset word.
- Undefined: the `loaded` port and its flip-flop do not exist. All other behaviour is identical.

## Test plan
- Reset: RESET=0, w=0, in=16'b0110101010110011, rising edge -> out=0 and OPCODE, REGISTER_ADRESS, REGISTER_ADRESS_STACK, IMMEDIATE, BA all 0; loaded=0.
- Load: RESET=1, w=1, in=16'b0110101010110011, rising edge -> out=16'b0110101010110011, OPCODE=6'b011010, REGISTER_ADRESS=1, REGISTER_ADRESS_STACK=2'b10, IMMEDIATE=9'b010110011, BA=10'b1010110011; loaded=1.
- Hold: after the load above, in=16'b0001011011110100, RESET=1, w=0, rising edge -> all outputs unchanged from the load scenario.
- Reset priority: RESET=0, w=1, in=16'hFFFF, rising edge -> out=0 and all fields 0; loaded=0.
- Field boundaries: load in=16'hFC00 -> OPCODE=6'h3F, BA=0, IMMEDIATE=0, REGISTER_ADRESS_STACK=0. Then load in=16'h03FF -> OPCODE=0, BA=10'h3FF, IMMEDIATE=9'h1FF, REGISTER_ADRESS=1, REGISTER_ADRESS_STACK=2'b11.
- Back-to-back writes: w=1 for three edges with in=16'h1234, 16'h5678, 16'h9ABC -> out shows each value the edge it is sampled, ending at 16'h9ABC with OPCODE=6'b100110.
